sonar_dwell_scheduler: RTL and testbench

//  Sequences the sonar front end one dwell at a time: sets the beam angle, then drives a transmit burst window.

---
 rtl/sonar_pkg.sv | 26 ++
 rtl/dwell_timer.sv | 36 +++
 rtl/sonar_dwell_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_sonar_dwell_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar dwell scheduler.
// Defaults assume a 100 MHz system clock.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_BURST,
        ST_LISTEN,
        ST_REPORT
    } dwell_state_t;

    localparam int DEF_ANGLE_WIDTH   = 8;
    localparam int DEF_ANGLE_MIN     = -30;
    localparam int DEF_ANGLE_MAX     = 30;
    localparam int DEF_ANGLE_STEP    = 10;
    localparam int DEF_BURST_CYCLES  = 524288;
    localparam int DEF_LISTEN_CYCLES = 16252928;
    localparam int DEF_SAMPLE_PERIOD = 100;
    localparam int RANGE_WIDTH       = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; done_out flags the terminal count while enabled.
// A load takes priority over counting, so a reload on done restarts cleanly.
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_value_in,
    input  logic             enable_in,
    output logic             done_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_value_in;
        end else if (enable_in && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_out = enable_in && (count_q == '0);

endmodule

// File: rtl/sonar_dwell_scheduler.sv
// Dwell sequencer: SETUP -> BURST -> LISTEN -> REPORT, one beam angle per dwell,
// sweeping ANGLE_MIN..ANGLE_MAX or holding a fixed angle.
module sonar_dwell_scheduler
    import sonar_pkg::*;
#(
    parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
    parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int LISTEN_CYCLES = DEF_LISTEN_CYCLES,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic                          sweep_mode_in,
    input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
    input  logic                          echo_valid_in,
    input  logic [RANGE_WIDTH-1:0]        range_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          burst_start_out,
    output logic                          tx_active_out,
    output logic                          sample_trigger_out,
    output logic                          result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic [RANGE_WIDTH-1:0]        result_range_out,
    output logic                          result_hit_out,
    output logic                          sweep_done_out
);

    generate
        if ((ANGLE_STEP <= 0) || (ANGLE_MAX < ANGLE_MIN) ||
            (((ANGLE_MAX - ANGLE_MIN) % ANGLE_STEP) != 0)) begin : g_bad_sweep
            $error("sonar_dwell_scheduler: sweep range is not a whole number of steps");
        end
    endgenerate

    localparam int WIN_W  = $clog2(max_int(BURST_CYCLES, LISTEN_CYCLES) + 1);
    localparam int SAMP_W = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [WIN_W-1:0]  BURST_LOAD  = WIN_W'(BURST_CYCLES - 1);
    localparam logic [WIN_W-1:0]  LISTEN_LOAD = WIN_W'(LISTEN_CYCLES - 1);
    localparam logic [SAMP_W-1:0] SAMP_LOAD   = SAMP_W'(SAMPLE_PERIOD - 1);

    localparam logic signed [ANGLE_WIDTH-1:0] ANG_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] ANG_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH-1:0] ANG_STEP = ANGLE_WIDTH'(ANGLE_STEP);

    dwell_state_t state_q, state_d;

    logic signed [ANGLE_WIDTH-1:0] beam_q, beam_d;
    logic signed [ANGLE_WIDTH-1:0] idx_q, idx_d;
    logic                          mode_q, mode_d;
    logic                          hit_q, hit_d;
    logic [RANGE_WIDTH-1:0]        range_q, range_d;
    logic                          burst_start_q, burst_start_d;
    logic                          res_valid_q, res_valid_d;
    logic signed [ANGLE_WIDTH-1:0] res_angle_q, res_angle_d;
    logic [RANGE_WIDTH-1:0]        res_range_q, res_range_d;
    logic                          res_hit_q, res_hit_d;
    logic                          sweep_done_q, sweep_done_d;

    logic                          win_done;
    logic                          win_load;
    logic [WIN_W-1:0]              win_load_value;
    logic                          in_window;
    logic                          samp_done;
    logic                          samp_load;
    logic [SAMP_W-1:0]             samp_load_value;
    logic                          hit_now;
    logic [RANGE_WIDTH-1:0]        range_now;

    // One timer paces both windows: BURST length loaded from SETUP, LISTEN length at end of BURST.
    assign in_window      = (state_q == ST_BURST) || (state_q == ST_LISTEN);
    assign win_load       = (state_q == ST_SETUP) || ((state_q == ST_BURST) && win_done);
    assign win_load_value = (state_q == ST_SETUP) ? BURST_LOAD : LISTEN_LOAD;

    dwell_timer #(
        .WIDTH(WIN_W)
    ) u_window_timer (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_in       (win_load),
        .load_value_in (win_load_value),
        .enable_in     (in_window),
        .done_out      (win_done)
    );

    // Loading zero as LISTEN begins makes the first strobe land on LISTEN cycle 0.
    assign samp_load       = ((state_q == ST_BURST) && win_done) || samp_done;
    assign samp_load_value = samp_done ? SAMP_LOAD : '0;

    dwell_timer #(
        .WIDTH(SAMP_W)
    ) u_sample_timer (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_in       (samp_load),
        .load_value_in (samp_load_value),
        .enable_in     (state_q == ST_LISTEN),
        .done_out      (samp_done)
    );

    // An echo on the final LISTEN cycle must still reach the result registers.
    assign hit_now   = hit_q || echo_valid_in;
    assign range_now = hit_q ? range_q : (echo_valid_in ? range_in : '0);

    always_comb begin
        state_d       = state_q;
        beam_d        = beam_q;
        idx_d         = idx_q;
        mode_d        = mode_q;
        hit_d         = hit_q;
        range_d       = range_q;
        burst_start_d = 1'b0;
        res_valid_d   = 1'b0;
        res_angle_d   = res_angle_q;
        res_range_d   = res_range_q;
        res_hit_d     = res_hit_q;
        sweep_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d       = ST_BURST;
                beam_d        = sweep_mode_in ? idx_q : fixed_angle_in;
                mode_d        = sweep_mode_in;
                hit_d         = 1'b0;
                range_d       = '0;
                burst_start_d = 1'b1;
            end
            ST_BURST: begin
                if (win_done) begin
                    state_d = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                if (echo_valid_in && !hit_q) begin
                    hit_d   = 1'b1;
                    range_d = range_in;
                end
                if (win_done) begin
                    state_d      = ST_REPORT;
                    res_valid_d  = 1'b1;
                    res_angle_d  = beam_q;
                    res_range_d  = range_now;
                    res_hit_d    = hit_now;
                    sweep_done_d = mode_q && (beam_q == ANG_MAX);
                end
            end
            ST_REPORT: begin
                state_d = enable_in ? ST_SETUP : ST_IDLE;
                if (mode_q) begin
                    idx_d = (idx_q == ANG_MAX) ? ANG_MIN : (idx_q + ANG_STEP);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            beam_q        <= '0;
            idx_q         <= ANG_MIN;
            mode_q        <= 1'b0;
            hit_q         <= 1'b0;
            range_q       <= '0;
            burst_start_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_angle_q   <= '0;
            res_range_q   <= '0;
            res_hit_q     <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            beam_q        <= beam_d;
            idx_q         <= idx_d;
            mode_q        <= mode_d;
            hit_q         <= hit_d;
            range_q       <= range_d;
            burst_start_q <= burst_start_d;
            res_valid_q   <= res_valid_d;
            res_angle_q   <= res_angle_d;
            res_range_q   <= res_range_d;
            res_hit_q     <= res_hit_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    assign beam_angle_out     = beam_q;
    assign burst_start_out    = burst_start_q;
    assign tx_active_out      = (state_q == ST_BURST);
    assign sample_trigger_out = samp_done;
    assign result_valid_out   = res_valid_q;
    assign result_angle_out   = res_angle_q;
    assign result_range_out   = res_range_q;
    assign result_hit_out     = res_hit_q;
    assign sweep_done_out     = sweep_done_q;

endmodule

// File: tb/tb_sonar_dwell_scheduler.sv
// Directed bench for sonar_dwell_scheduler with short windows (8 burst, 40 listen, strobe every 10).
// Dwell cycle numbering: 0 = SETUP, 1..8 = BURST, 9..48 = LISTEN (k -> 9+k), 49 = REPORT.
module tb_sonar_dwell_scheduler;

    localparam int NV = 11;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              enable_in;
    logic              sweep_mode_in;
    logic signed [7:0] fixed_angle_in;
    logic              echo_valid_in;
    logic [15:0]       range_in;
    logic signed [7:0] beam_angle_out;
    logic              burst_start_out;
    logic              tx_active_out;
    logic              sample_trigger_out;
    logic              result_valid_out;
    logic signed [7:0] result_angle_out;
    logic [15:0]       result_range_out;
    logic              result_hit_out;
    logic              sweep_done_out;

    always #5 clk_in = ~clk_in;

    sonar_dwell_scheduler #(
        .ANGLE_WIDTH   (8),
        .ANGLE_MIN     (-30),
        .ANGLE_MAX     (30),
        .ANGLE_STEP    (10),
        .BURST_CYCLES  (8),
        .LISTEN_CYCLES (40),
        .SAMPLE_PERIOD (10)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .enable_in          (enable_in),
        .sweep_mode_in      (sweep_mode_in),
        .fixed_angle_in     (fixed_angle_in),
        .echo_valid_in      (echo_valid_in),
        .range_in           (range_in),
        .beam_angle_out     (beam_angle_out),
        .burst_start_out    (burst_start_out),
        .tx_active_out      (tx_active_out),
        .sample_trigger_out (sample_trigger_out),
        .result_valid_out   (result_valid_out),
        .result_angle_out   (result_angle_out),
        .result_range_out   (result_range_out),
        .result_hit_out     (result_hit_out),
        .sweep_done_out     (sweep_done_out)
    );

    typedef struct {
        bit sweep;
        int fixed;
        int ea;        // dwell cycle of first echo, -1 = none
        int ra;
        int eb;        // dwell cycle of second echo, -1 = none
        int rb;
        int exp_angle;
        int exp_hit;
        int exp_range;
        int exp_done;
    } vec_t;

    vec_t vecs [NV];
    vec_t v_resume;
    vec_t v_post;

    int n_checks = 0;
    int n_pass   = 0;
    bit prev_ok  = 1'b0;
    int prev_angle;
    int prev_range;

    function automatic vec_t mk(bit sweep, int fixed, int ea, int ra, int eb, int rb,
                                int ang, int hit, int rng, int done);
        vec_t v;
        v.sweep = sweep; v.fixed = fixed;
        v.ea = ea; v.ra = ra; v.eb = eb; v.rb = rb;
        v.exp_angle = ang; v.exp_hit = hit; v.exp_range = rng; v.exp_done = done;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_dwell(input vec_t v, input vec_t nxt, input int drop_at, input string tag);
        int n;
        int tx_cnt;
        int bs_cnt;
        int rv_cnt;
        int beam_bad;
        logic [63:0] strobe_mask;
        logic [63:0] exp_mask;
        n = 0;
        do begin
            @(negedge clk_in);
            echo_valid_in = 1'b0;
            range_in      = 16'h0;
            n++;
        end while (!burst_start_out && n < 100);
        check({tag, " start latency"}, n, 2);
        if (!burst_start_out) return;
        sweep_mode_in  = nxt.sweep;
        fixed_angle_in = 8'(nxt.fixed);
        tx_cnt = 0; bs_cnt = 0; rv_cnt = 0; beam_bad = 0;
        strobe_mask = '0;
        exp_mask    = '0;
        for (int k = 0; k < 4; k++) exp_mask[9 + 10 * k] = 1'b1;
        for (int c = 1; c <= 49; c++) begin
            if (c > 1) @(negedge clk_in);
            tx_cnt += int'(tx_active_out);
            bs_cnt += int'(burst_start_out);
            rv_cnt += int'(result_valid_out);
            if (sample_trigger_out) strobe_mask[c] = 1'b1;
            if (int'(beam_angle_out) != v.exp_angle) beam_bad++;
            if (c == 5 && prev_ok) begin
                check({tag, " held angle"}, int'(result_angle_out), prev_angle);
                check({tag, " held range"}, int'(result_range_out), prev_range);
            end
            if (c == 49) begin
                check({tag, " result_valid"}, int'(result_valid_out), 1);
                check({tag, " result_angle"}, int'(result_angle_out), v.exp_angle);
                check({tag, " result_hit"}, int'(result_hit_out), v.exp_hit);
                check({tag, " result_range"}, int'(result_range_out), v.exp_range);
                check({tag, " sweep_done"}, int'(sweep_done_out), v.exp_done);
                $display("dwell %s: angle=%0d hit=%0d range=0x%04h done=%0d", tag,
                         int'(result_angle_out), result_hit_out, result_range_out, sweep_done_out);
            end
            echo_valid_in = (c == v.ea) || (c == v.eb);
            range_in      = (c == v.ea) ? 16'(v.ra) : ((c == v.eb) ? 16'(v.rb) : 16'h0);
            if (c == drop_at) enable_in = 1'b0;
        end
        check({tag, " tx_active cycles"}, tx_cnt, 8);
        check({tag, " burst_start pulses"}, bs_cnt, 1);
        check({tag, " result_valid pulses"}, rv_cnt, 1);
        check({tag, " beam angle unstable cycles"}, beam_bad, 0);
        check({tag, " strobe pattern"}, longint'(strobe_mask), longint'(exp_mask));
        prev_ok    = 1'b1;
        prev_angle = v.exp_angle;
        prev_range = v.exp_range;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int act_cnt;
        // sweep fields for each dwell; echoes given as dwell cycles
        vecs[0]  = mk(1,   0, -1, 0,      -1, 0,      -30, 0, 0,      0);
        vecs[1]  = mk(1,   0, 14, 'h0123, 29, 'h0456, -20, 1, 'h0123, 0);
        vecs[2]  = mk(1,   0,  3, 'h0777, -1, 0,      -10, 0, 0,      0);
        vecs[3]  = mk(1,   0, 48, 'h0abc, -1, 0,        0, 1, 'h0abc, 0);
        vecs[4]  = mk(1,   0, 49, 'h0999, -1, 0,       10, 0, 0,      0);
        vecs[5]  = mk(1,   0, -1, 0,      -1, 0,       20, 0, 0,      0);
        vecs[6]  = mk(1,   0, -1, 0,      -1, 0,       30, 0, 0,      1);
        vecs[7]  = mk(1,   0, -1, 0,      -1, 0,      -30, 0, 0,      0);
        vecs[8]  = mk(0, -20,  9, 'h0042, -1, 0,      -20, 1, 'h0042, 0);
        vecs[9]  = mk(0, -20, -1, 0,      -1, 0,      -20, 0, 0,      0);
        vecs[10] = mk(1,   0, 20, 'h0321, -1, 0,      -20, 1, 'h0321, 0);
        v_resume = mk(1,   0, -1, 0,      -1, 0,      -10, 0, 0,      0);
        v_post   = mk(1,   0, -1, 0,      -1, 0,      -30, 0, 0,      0);

        rst_in = 1'b1; enable_in = 1'b0; sweep_mode_in = 1'b1; fixed_angle_in = '0;
        echo_valid_in = 1'b0; range_in = '0;
        repeat (3) @(negedge clk_in);
        check("reset beam_angle", int'(beam_angle_out), 0);
        check("reset outputs", {burst_start_out, tx_active_out, sample_trigger_out, result_valid_out,
                                result_hit_out, sweep_done_out, result_angle_out, result_range_out}, 0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        sweep_mode_in  = vecs[0].sweep;
        fixed_angle_in = 8'(vecs[0].fixed);
        enable_in      = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_dwell(vecs[i], (i < NV - 1) ? vecs[i + 1] : v_resume,
                      (i == NV - 1) ? 20 : 0, $sformatf("v%0d", i));
        end

        act_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            act_cnt += int'(burst_start_out) + int'(tx_active_out) + int'(sample_trigger_out)
                     + int'(result_valid_out);
        end
        check("idle activity after enable drop", act_cnt, 0);

        enable_in = 1'b1;
        run_dwell(v_resume, v_resume, 0, "resume");

        n = 0;
        do begin
            @(negedge clk_in);
            echo_valid_in = 1'b0;
            n++;
        end while (!burst_start_out && n < 100);
        check("next dwell start latency", n, 2);
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("async reset tx_active", int'(tx_active_out), 0);
        check("async reset beam_angle", int'(beam_angle_out), 0);
        check("async reset results", {result_valid_out, result_hit_out, sweep_done_out,
                                      result_angle_out, result_range_out}, 0);
        check("async reset strobes", {burst_start_out, sample_trigger_out}, 0);
        repeat (2) @(negedge clk_in);
        rst_in  = 1'b0;
        prev_ok = 1'b0;
        run_dwell(v_post, v_post, 0, "post-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
